// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - default widths, depth and reset PC for the fetch stage
package fetch_unit_pkg;

    localparam int DEFAULT_INSTRUCTION_WIDTH = 24;
    localparam int DEFAULT_PC_WIDTH          = 12;
    localparam int DEFAULT_FIFO_DEPTH        = 2;
    localparam int DEFAULT_RESET_PC          = 0;

    // Bits needed to hold a count from 0 up to and including depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small in-order shift FIFO with sync clear and registered head
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CW = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [CW-1:0]    count_o,
    output logic             head_valid_o,
    output logic [WIDTH-1:0] head_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    wr_idx;
    logic             do_pop, do_push;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (do_pop || (int'(count_q) < DEPTH));
    assign wr_idx  = do_pop ? count_q - CW'(1) : count_q;

    // Entry 0 is always the head, so the head outputs come straight from flops.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
                count_d = count_q - CW'(1);
            end
            if (do_push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_idx == CW'(i)) mem_d[i] = push_data_i;
                end
                count_d = count_d + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_data_o  = mem_q[0];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, credit-limited imem requests and flushable instruction buffer
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
    parameter int PC_WIDTH          = DEFAULT_PC_WIDTH,
    parameter int FIFO_DEPTH        = DEFAULT_FIFO_DEPTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [PC_WIDTH-1:0]          imem_req_addr,
    input  logic                         imem_resp_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_resp_data,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [INSTRUCTION_WIDTH-1:0] inst_data,
    output logic [PC_WIDTH-1:0]          inst_pc,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH-1:0]          redirect_pc
);

    localparam int CW = count_width(FIFO_DEPTH);
    localparam int SW = CW + 2;
    localparam int EW = INSTRUCTION_WIDTH + PC_WIDTH;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]       outstanding_q, outstanding_d;
    logic [CW-1:0]       discard_q, discard_d;
    logic [CW-1:0]       occupancy, tag_count;
    logic [SW-1:0]       committed;
    logic                req_fire, resp_owed, resp_live, inst_push, inst_pop;
    logic                tag_valid;
    logic [PC_WIDTH-1:0] tag_pc;
    logic [EW-1:0]       inst_entry;

    // Every slot already promised (buffered, in flight, or owed from a flushed path)
    // counts against the buffer, so a returning word always has room.
    assign committed      = SW'(occupancy) + SW'(outstanding_q) + SW'(discard_q);
    assign imem_req_valid = !reset && !redirect_valid && (committed < SW'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_owed      = imem_resp_valid && (discard_q != '0);
    assign resp_live      = imem_resp_valid && (discard_q == '0);
    assign inst_push      = resp_live && !redirect_valid;
    assign inst_pop       = inst_valid && inst_ready;
    assign inst_data      = inst_entry[EW-1:PC_WIDTH];
    assign inst_pc        = inst_entry[PC_WIDTH-1:0];

    fetch_fifo #(.WIDTH(PC_WIDTH), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (redirect_valid),
        .push_i       (req_fire),
        .push_data_i  (pc_q),
        .pop_i        (resp_live),
        .count_o      (tag_count),
        .head_valid_o (tag_valid),
        .head_data_o  (tag_pc)
    );

    fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_inst_fifo (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (redirect_valid),
        .push_i       (inst_push),
        .push_data_i  ({imem_resp_data, tag_pc}),
        .pop_i        (inst_pop),
        .count_o      (occupancy),
        .head_valid_o (inst_valid),
        .head_data_o  (inst_entry)
    );

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)
            pc_d = redirect_pc;
        else if (req_fire)
            pc_d = pc_q + PC_WIDTH'(1);
    end

    // On a flush, everything still owed by memory (including any word arriving this
    // very cycle) is reclassified as owed-to-discard.
    always_comb begin
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect_valid) begin
            outstanding_d = '0;
            discard_d     = discard_q + outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
        end else begin
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_live);
            discard_d     = discard_q - CW'(resp_owed);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

`ifndef SYNTHESIS
    a_credit: assert property (@(posedge clk) disable iff (reset)
        committed <= SW'(FIFO_DEPTH))
        else $error("fetch_unit: committed slots exceed buffer depth");
    a_resp_owed: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> (outstanding_q != '0 || discard_q != '0))
        else $error("fetch_unit: response with nothing outstanding");
    a_tags: assert property (@(posedge clk) disable iff (reset)
        (tag_count == outstanding_q) && (!resp_live || tag_valid))
        else $error("fetch_unit: request tag queue out of step");
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized fetch_unit bench against a queue-based reference model
module tb_fetch_unit;

    localparam int IW    = 24;
    localparam int PW    = 12;
    localparam int DEPTH = 2;
    localparam logic [PW-1:0] RPC = 12'h000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req_valid, imem_req_ready = 1'b0;
    logic [PW-1:0] imem_req_addr;
    logic          imem_resp_valid = 1'b0;
    logic [IW-1:0] imem_resp_data = '0;
    logic          inst_valid, inst_ready = 1'b0;
    logic [IW-1:0] inst_data;
    logic [PW-1:0] inst_pc;
    logic          redirect_valid = 1'b0;
    logic [PW-1:0] redirect_pc = '0;

    fetch_unit #(
        .INSTRUCTION_WIDTH (IW),
        .PC_WIDTH          (PW),
        .FIFO_DEPTH        (DEPTH),
        .RESET_PC          (RPC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    initial forever #5 clk = ~clk;

    // Reference model: accepted requests in order, each flagged live or flushed,
    // and the buffer of instructions decode has yet to take.
    logic [PW-1:0] infl_addr[$];
    bit            infl_live[$];
    logic [IW-1:0] buf_data[$];
    logic [PW-1:0] buf_pc[$];
    int            mem_due[$];
    logic [PW-1:0] mem_addr[$];
    logic [PW-1:0] pc_m = RPC;
    bit            modelled_reset = 0;
    bit            reset_state = 0;
    int            cyc = 0;
    int            last_due = 0;
    int            lat = 1;
    int            vectors = 0;
    int            miscompares = 0;
    logic [PW-1:0] req_log[$];
    logic [PW-1:0] dec_log[$];
    logic          last_valid;
    logic [PW-1:0] last_pc;

    function automatic logic [IW-1:0] word(input logic [PW-1:0] a);
        return {a ^ 12'hC35, a};
    endfunction

    function automatic logic [31:0] at(input logic [PW-1:0] q[$], input int i);
        if (i < q.size()) return 32'(q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit rdy, input bit irdy, input bit redir,
                        input logic [PW-1:0] rpc);
        bit            rd, resp, exp_req, fire, pop;
        logic [PW-1:0] raddr;
        int            due;
        @(negedge clk);
        rd              = redir && !rst;
        reset           = rst;
        imem_req_ready  = rdy;
        inst_ready      = irdy;
        redirect_valid  = rd;
        redirect_pc     = rpc;
        resp            = !rst && (mem_due.size() > 0) && (mem_due[0] == cyc);
        raddr           = resp ? mem_addr[0] : '0;
        imem_resp_valid = resp;
        imem_resp_data  = resp ? word(raddr) : '0;
        #1;
        exp_req = !rst && !rd && (buf_pc.size() + infl_addr.size() < DEPTH);
        if (modelled_reset) begin
            chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
            chk("req_addr", 32'(imem_req_addr), 32'(pc_m));
            chk("inst_valid", 32'(inst_valid), 32'(buf_pc.size() > 0));
            if (buf_pc.size() > 0) begin
                chk("inst_data", 32'(inst_data), 32'(buf_data[0]));
                chk("inst_pc", 32'(inst_pc), 32'(buf_pc[0]));
            end
            if (reset_state) begin
                chk("rst_inst_data", 32'(inst_data), 32'h0);
                chk("rst_inst_pc", 32'(inst_pc), 32'h0);
            end
        end
        last_valid = inst_valid;
        last_pc    = inst_pc;
        if (imem_req_valid && rdy) req_log.push_back(imem_req_addr);
        if (inst_valid && irdy && !rd) dec_log.push_back(inst_pc);

        if (rst) begin
            infl_addr.delete(); infl_live.delete();
            buf_data.delete();  buf_pc.delete();
            mem_due.delete();   mem_addr.delete();
            pc_m = RPC; last_due = 0;
            modelled_reset = 1; reset_state = 1;
        end else begin
            reset_state = 0;
            fire = exp_req && rdy;
            pop  = (buf_pc.size() > 0) && irdy;
            if (pop) begin
                void'(buf_data.pop_front());
                void'(buf_pc.pop_front());
            end
            if (resp) begin
                void'(mem_due.pop_front());
                void'(mem_addr.pop_front());
                if (infl_addr.size() > 0) begin
                    if (infl_live[0] && !rd) begin
                        buf_data.push_back(word(infl_addr[0]));
                        buf_pc.push_back(infl_addr[0]);
                    end
                    void'(infl_addr.pop_front());
                    void'(infl_live.pop_front());
                end
            end
            if (rd) begin
                for (int i = 0; i < infl_live.size(); i++) infl_live[i] = 0;
                buf_data.delete(); buf_pc.delete();
                pc_m = rpc;
            end
            if (fire) begin
                infl_addr.push_back(pc_m);
                infl_live.push_back(1);
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                mem_due.push_back(due);
                mem_addr.push_back(pc_m);
                last_due = due;
                pc_m = pc_m + 12'h001;
            end
        end
        cyc++;
    endtask

    initial begin
        bit hit;

        repeat (3) step(1, 0, 0, 0, '0);

        // Free run, latency 1.
        req_log.delete(); dec_log.delete();
        repeat (20) step(0, 1, 1, 0, '0);
        for (int i = 0; i < 4; i++) begin
            chk("free_req_addr", at(req_log, i), 32'(i));
            chk("free_dec_pc", at(dec_log, i), 32'(i));
        end

        // Decode stalled right after reset: only two requests go out, nothing is lost.
        repeat (2) step(1, 0, 0, 0, '0);
        req_log.delete(); dec_log.delete();
        repeat (10) step(0, 1, 0, 0, '0);
        chk("bp_req_count", 32'(req_log.size()), 32'd2);
        chk("bp_dec_count", 32'(dec_log.size()), 32'd0);
        repeat (10) step(0, 1, 1, 0, '0);
        for (int i = 0; i < 4; i++) chk("bp_dec_order", at(dec_log, i), 32'(i));

        // Redirect with two requests in flight on a latency-2 memory.
        lat = 2;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (infl_addr.size() == 2) hit = 1;
            else step(0, 1, 1, 0, '0);
        end
        chk("wait_two_outstanding", 32'(hit), 32'd1);
        dec_log.delete();
        step(0, 1, 1, 1, 12'h040);
        repeat (12) step(0, 1, 1, 0, '0);
        chk("redir_first_dec", at(dec_log, 0), 32'h040);

        // Redirect in the same cycle as a response and a pop.
        lat = 1;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (mem_due.size() > 0 && mem_due[0] == cyc && buf_pc.size() > 0) hit = 1;
            else step(0, 1, 1, 0, '0);
        end
        chk("wait_resp_and_pop", 32'(hit), 32'd1);
        dec_log.delete();
        step(0, 1, 1, 1, 12'h123);
        repeat (12) step(0, 1, 1, 0, '0);
        chk("coinc_first_dec", at(dec_log, 0), 32'h123);
        chk("coinc_second_dec", at(dec_log, 1), 32'h124);

        // PC wrap from an idle pipeline; target reaches decode three cycles later.
        repeat (5) step(0, 0, 1, 0, '0);
        req_log.delete();
        step(0, 1, 1, 1, 12'hFFE);
        step(0, 1, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        chk("wrap_t3_valid", 32'(last_valid), 32'd1);
        chk("wrap_t3_pc", 32'(last_pc), 32'hFFE);
        repeat (10) step(0, 1, 1, 0, '0);
        chk("wrap_req0", at(req_log, 0), 32'hFFE);
        chk("wrap_req1", at(req_log, 1), 32'hFFF);
        chk("wrap_req2", at(req_log, 2), 32'h000);
        chk("wrap_req3", at(req_log, 3), 32'h001);

        // Random traffic with varying memory latency, stalls and redirects.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) lat = $urandom_range(1, 3);
            step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0, 12'($urandom));
        end

        // Reset in the middle of traffic with a full buffer.
        lat = 1;
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (buf_pc.size() == DEPTH) hit = 1;
            else step(0, 1, 0, 0, '0);
        end
        chk("wait_buffer_full", 32'(hit), 32'd1);
        step(1, 1, 1, 0, '0);
        req_log.delete(); dec_log.delete();
        step(0, 1, 1, 0, '0);
        chk("midrst_inst_valid", 32'(last_valid), 32'd0);
        repeat (8) step(0, 1, 1, 0, '0);
        chk("midrst_req0", at(req_log, 0), 32'(RPC));
        chk("midrst_dec0", at(dec_log, 0), 32'(RPC));

        for (int i = 0; i < 500; i++) begin
            step(0, $urandom_range(0, 1) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, 12'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
